// File: rtl/reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// reg_write_arbiter
//
// Shares the single write port of the register file between two requesters:
// ALU writeback (data write) and the move unit (register-to-register copy).
// It also keeps a per-register busy scoreboard so decode can stall on reads
// of registers whose write is still in flight.
//
// Ports
//   clk, reset        : system clock; asynchronous active-high reset
//   alu_valid/ready   : ALU write request handshake (ready is combinational)
//   alu_dest/alu_data : ALU destination register and write data
//   mov_valid/ready   : move request handshake (ready is combinational)
//   mov_dest/mov_src  : move destination and source registers
//   reserve_en/num    : decode marks a register busy
//   check_num/busy    : decode asks whether a register is busy
//   busy_any          : at least one register is busy
//   write_enabled, reg_to_reg, reg_write_number, reg_from_number,
//   reg_write_data    : registered command to the register file
// ---------------------------------------------------------------------------
module reg_write_arbiter #(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         alu_valid,
    output logic         alu_ready,
    input  logic [D-1:0] alu_dest,
    input  logic [W-1:0] alu_data,
    input  logic         mov_valid,
    output logic         mov_ready,
    input  logic [D-1:0] mov_dest,
    input  logic [D-1:0] mov_src,
    input  logic         reserve_en,
    input  logic [D-1:0] reserve_num,
    input  logic [D-1:0] check_num,
    output logic         check_busy,
    output logic         busy_any,
    output logic         write_enabled,
    output logic         reg_to_reg,
    output logic [D-1:0] reg_write_number,
    output logic [D-1:0] reg_from_number,
    output logic [W-1:0] reg_write_data
);

    localparam int NREG = 2 ** D;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MOV = 1'b1
    } grant_t;

    grant_t            last_grant_q;
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;
    logic              we_q;
    logic              r2r_q;
    logic [D-1:0]      wnum_q;
    logic [D-1:0]      fnum_q;
    logic [W-1:0]      wdata_q;

    logic              alu_elig_s;
    logic              mov_elig_s;
    logic              grant_alu_s;
    logic              grant_mov_s;
    logic [NREG-1:0]   set_mask_s;
    logic [NREG-1:0]   clr_mask_s;

    // Eligibility and round-robin grant; nothing is accepted while in reset.
    always_comb begin
        alu_elig_s  = 1'b0;
        mov_elig_s  = 1'b0;
        grant_alu_s = 1'b0;
        grant_mov_s = 1'b0;
        if (reset) begin
            alu_elig_s = 1'b0;
            mov_elig_s = 1'b0;
        end else begin
            alu_elig_s = alu_valid;
            // A move whose source is still being written would copy stale data.
            mov_elig_s = mov_valid & ~busy_q[mov_src];
        end
        case ({alu_elig_s, mov_elig_s})
            2'b10:   grant_alu_s = 1'b1;
            2'b01:   grant_mov_s = 1'b1;
            2'b11: begin
                // Tie: the requester that was not granted last goes first.
                grant_alu_s = (last_grant_q == GRANT_MOV);
                grant_mov_s = (last_grant_q == GRANT_ALU);
            end
            default: begin
                grant_alu_s = 1'b0;
                grant_mov_s = 1'b0;
            end
        endcase
    end

    // Scoreboard next state: the command driven this cycle retires its
    // destination at the clock edge, but a same-cycle reservation wins.
    always_comb begin
        set_mask_s = {NREG{1'b0}};
        clr_mask_s = {NREG{1'b0}};
        if (reserve_en) begin
            set_mask_s[reserve_num] = 1'b1;
        end else begin
            set_mask_s = {NREG{1'b0}};
        end
        if (we_q | r2r_q) begin
            clr_mask_s[wnum_q] = 1'b1;
        end else begin
            clr_mask_s = {NREG{1'b0}};
        end
        busy_d = (busy_q & ~clr_mask_s) | set_mask_s;
    end

    // Grant pointer and scoreboard state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= GRANT_MOV;
            busy_q       <= {NREG{1'b0}};
        end else begin
            busy_q <= busy_d;
            if (grant_alu_s) begin
                last_grant_q <= GRANT_ALU;
            end else if (grant_mov_s) begin
                last_grant_q <= GRANT_MOV;
            end else begin
                last_grant_q <= last_grant_q;
            end
        end
    end

    // Registered command to the register file; index/data hold when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            r2r_q   <= 1'b0;
            wnum_q  <= {D{1'b0}};
            fnum_q  <= {D{1'b0}};
            wdata_q <= {W{1'b0}};
        end else begin
            we_q  <= grant_alu_s;
            r2r_q <= grant_mov_s;
            if (grant_alu_s) begin
                wnum_q  <= alu_dest;
                wdata_q <= alu_data;
            end else if (grant_mov_s) begin
                wnum_q <= mov_dest;
                fnum_q <= mov_src;
            end else begin
                wnum_q <= wnum_q;
            end
        end
    end

    assign alu_ready        = grant_alu_s;
    assign mov_ready        = grant_mov_s;
    assign check_busy       = busy_q[check_num];
    assign busy_any         = |busy_q;
    assign write_enabled    = we_q;
    assign reg_to_reg       = r2r_q;
    assign reg_write_number = wnum_q;
    assign reg_from_number  = fnum_q;
    assign reg_write_data   = wdata_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_write_arbiter
//
// Directed bench: a table of per-cycle vectors with hand-computed
// expectations, applied as one continuous sequence after reset, followed by
// a hand-written sequence for reset asserted with a command in flight.
// Inputs change on the falling edge; combinational outputs are checked just
// after that, registered outputs 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_reg_write_arbiter;

    logic       clk;
    logic       reset;
    logic       alu_valid;
    logic       alu_ready;
    logic [3:0] alu_dest;
    logic [7:0] alu_data;
    logic       mov_valid;
    logic       mov_ready;
    logic [3:0] mov_dest;
    logic [3:0] mov_src;
    logic       reserve_en;
    logic [3:0] reserve_num;
    logic [3:0] check_num;
    logic       check_busy;
    logic       busy_any;
    logic       write_enabled;
    logic       reg_to_reg;
    logic [3:0] reg_write_number;
    logic [3:0] reg_from_number;
    logic [7:0] reg_write_data;

    int tests_run;
    int tests_failed;

    reg_write_arbiter #(.W(8), .D(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .alu_valid        (alu_valid),
        .alu_ready        (alu_ready),
        .alu_dest         (alu_dest),
        .alu_data         (alu_data),
        .mov_valid        (mov_valid),
        .mov_ready        (mov_ready),
        .mov_dest         (mov_dest),
        .mov_src          (mov_src),
        .reserve_en       (reserve_en),
        .reserve_num      (reserve_num),
        .check_num        (check_num),
        .check_busy       (check_busy),
        .busy_any         (busy_any),
        .write_enabled    (write_enabled),
        .reg_to_reg       (reg_to_reg),
        .reg_write_number (reg_write_number),
        .reg_from_number  (reg_from_number),
        .reg_write_data   (reg_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       av;
        logic [3:0] ad;
        logic [7:0] adata;
        logic       mv;
        logic [3:0] md;
        logic [3:0] ms;
        logic       re;
        logic [3:0] rn;
        logic [3:0] cn;
        logic       e_ar;   // before the edge
        logic       e_mr;
        logic       e_cb;
        logic       e_we;   // after the edge
        logic       e_rr;
        logic [3:0] e_wn;
        logic [3:0] e_fn;
        logic [7:0] e_wd;
        logic       e_ba;
    } vec_t;

    vec_t vec [0:17];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive_idle();
        alu_valid   = 1'b0;
        alu_dest    = 4'd0;
        alu_data    = 8'h00;
        mov_valid   = 1'b0;
        mov_dest    = 4'd0;
        mov_src     = 4'd0;
        reserve_en  = 1'b0;
        reserve_num = 4'd0;
        check_num   = 4'd0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        //         av  ad    adata  mv  md    ms    re  rn    cn    ar  mr  cb  we  rr  wn    fn    wd     ba
        vec[0]  = '{1'b1,4'd3,8'hA5, 1'b0,4'd0,4'd0, 1'b0,4'd0,4'd0, 1'b1,1'b0,1'b0, 1'b1,1'b0,4'd3,4'd0,8'hA5,1'b0};
        vec[1]  = '{1'b1,4'd4,8'h3C, 1'b1,4'd6,4'd1, 1'b0,4'd0,4'd0, 1'b0,1'b1,1'b0, 1'b0,1'b1,4'd6,4'd1,8'hA5,1'b0};
        vec[2]  = '{1'b1,4'd4,8'h3C, 1'b1,4'd6,4'd1, 1'b0,4'd0,4'd0, 1'b1,1'b0,1'b0, 1'b1,1'b0,4'd4,4'd1,8'h3C,1'b0};
        vec[3]  = '{1'b1,4'd4,8'h3C, 1'b1,4'd7,4'd2, 1'b0,4'd0,4'd0, 1'b0,1'b1,1'b0, 1'b0,1'b1,4'd7,4'd2,8'h3C,1'b0};
        vec[4]  = '{1'b0,4'd0,8'h00, 1'b0,4'd0,4'd0, 1'b0,4'd0,4'd0, 1'b0,1'b0,1'b0, 1'b0,1'b0,4'd7,4'd2,8'h3C,1'b0};
        vec[5]  = '{1'b0,4'd0,8'h00, 1'b0,4'd0,4'd0, 1'b1,4'd5,4'd5, 1'b0,1'b0,1'b0, 1'b0,1'b0,4'd7,4'd2,8'h3C,1'b1};
        vec[6]  = '{1'b0,4'd0,8'h00, 1'b1,4'd2,4'd5, 1'b0,4'd0,4'd5, 1'b0,1'b0,1'b1, 1'b0,1'b0,4'd7,4'd2,8'h3C,1'b1};
        vec[7]  = '{1'b1,4'd5,8'h5A, 1'b1,4'd2,4'd5, 1'b0,4'd0,4'd5, 1'b1,1'b0,1'b1, 1'b1,1'b0,4'd5,4'd2,8'h5A,1'b1};
        vec[8]  = '{1'b0,4'd0,8'h00, 1'b1,4'd2,4'd5, 1'b0,4'd0,4'd5, 1'b0,1'b0,1'b1, 1'b0,1'b0,4'd5,4'd2,8'h5A,1'b0};
        vec[9]  = '{1'b0,4'd0,8'h00, 1'b1,4'd2,4'd5, 1'b0,4'd0,4'd5, 1'b0,1'b1,1'b0, 1'b0,1'b1,4'd2,4'd5,8'h5A,1'b0};
        vec[10] = '{1'b0,4'd0,8'h00, 1'b0,4'd0,4'd0, 1'b0,4'd0,4'd0, 1'b0,1'b0,1'b0, 1'b0,1'b0,4'd2,4'd5,8'h5A,1'b0};
        vec[11] = '{1'b1,4'd7,8'h77, 1'b0,4'd0,4'd0, 1'b0,4'd0,4'd7, 1'b1,1'b0,1'b0, 1'b1,1'b0,4'd7,4'd5,8'h77,1'b0};
        vec[12] = '{1'b0,4'd0,8'h00, 1'b0,4'd0,4'd0, 1'b1,4'd7,4'd7, 1'b0,1'b0,1'b0, 1'b0,1'b0,4'd7,4'd5,8'h77,1'b1};
        vec[13] = '{1'b0,4'd0,8'h00, 1'b0,4'd0,4'd0, 1'b0,4'd0,4'd7, 1'b0,1'b0,1'b1, 1'b0,1'b0,4'd7,4'd5,8'h77,1'b1};
        vec[14] = '{1'b1,4'd7,8'h11, 1'b0,4'd0,4'd0, 1'b0,4'd0,4'd7, 1'b1,1'b0,1'b1, 1'b1,1'b0,4'd7,4'd5,8'h11,1'b1};
        vec[15] = '{1'b0,4'd0,8'h00, 1'b0,4'd0,4'd0, 1'b0,4'd0,4'd7, 1'b0,1'b0,1'b1, 1'b0,1'b0,4'd7,4'd5,8'h11,1'b0};
        vec[16] = '{1'b0,4'd0,8'h00, 1'b0,4'd0,4'd0, 1'b0,4'd0,4'd7, 1'b0,1'b0,1'b0, 1'b0,1'b0,4'd7,4'd5,8'h11,1'b0};
        vec[17] = '{1'b0,4'd0,8'h00, 1'b1,4'd9,4'd9, 1'b0,4'd0,4'd9, 1'b0,1'b1,1'b0, 1'b0,1'b1,4'd9,4'd9,8'h11,1'b0};

        // Reset with both requesters asking: nothing may be accepted.
        drive_idle();
        reset     = 1'b1;
        alu_valid = 1'b1;
        mov_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_alu_ready", -1, {31'd0, alu_ready}, 32'd0);
        chk("rst_mov_ready", -1, {31'd0, mov_ready}, 32'd0);
        chk("rst_we",        -1, {31'd0, write_enabled}, 32'd0);
        chk("rst_rr",        -1, {31'd0, reg_to_reg}, 32'd0);
        chk("rst_wn",        -1, {28'd0, reg_write_number}, 32'd0);
        chk("rst_wd",        -1, {24'd0, reg_write_data}, 32'd0);
        chk("rst_busy_any",  -1, {31'd0, busy_any}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive_idle();

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            alu_valid   = vec[i].av;
            alu_dest    = vec[i].ad;
            alu_data    = vec[i].adata;
            mov_valid   = vec[i].mv;
            mov_dest    = vec[i].md;
            mov_src     = vec[i].ms;
            reserve_en  = vec[i].re;
            reserve_num = vec[i].rn;
            check_num   = vec[i].cn;
            #1;
            chk("alu_ready",  i, {31'd0, alu_ready},  {31'd0, vec[i].e_ar});
            chk("mov_ready",  i, {31'd0, mov_ready},  {31'd0, vec[i].e_mr});
            chk("check_busy", i, {31'd0, check_busy}, {31'd0, vec[i].e_cb});
            @(posedge clk);
            #1;
            chk("write_enabled",    i, {31'd0, write_enabled},    {31'd0, vec[i].e_we});
            chk("reg_to_reg",       i, {31'd0, reg_to_reg},       {31'd0, vec[i].e_rr});
            chk("reg_write_number", i, {28'd0, reg_write_number}, {28'd0, vec[i].e_wn});
            chk("reg_from_number",  i, {28'd0, reg_from_number},  {28'd0, vec[i].e_fn});
            chk("reg_write_data",   i, {24'd0, reg_write_data},   {24'd0, vec[i].e_wd});
            chk("busy_any",         i, {31'd0, busy_any},         {31'd0, vec[i].e_ba});
        end

        // Reset mid-cycle with an accepted ALU write in flight; last grant was
        // ALU, so only a cleared pointer lets the ALU win the next tie.
        @(negedge clk);
        drive_idle();
        alu_valid   = 1'b1;
        alu_dest    = 4'd3;
        alu_data    = 8'h42;
        reserve_en  = 1'b1;
        reserve_num = 4'd1;
        #1;
        chk("mr_alu_ready", 100, {31'd0, alu_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("mr_we_before", 100, {31'd0, write_enabled}, 32'd1);
        chk("mr_ba_before", 100, {31'd0, busy_any}, 32'd1);
        reserve_en = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk("mr_we",        101, {31'd0, write_enabled}, 32'd0);
        chk("mr_rr",        101, {31'd0, reg_to_reg}, 32'd0);
        chk("mr_wn",        101, {28'd0, reg_write_number}, 32'd0);
        chk("mr_fn",        101, {28'd0, reg_from_number}, 32'd0);
        chk("mr_wd",        101, {24'd0, reg_write_data}, 32'd0);
        chk("mr_busy_any",  101, {31'd0, busy_any}, 32'd0);
        chk("mr_alu_ready", 101, {31'd0, alu_ready}, 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        mov_valid = 1'b1;
        mov_dest  = 4'd1;
        mov_src   = 4'd0;
        #1;
        chk("tie_alu_ready", 102, {31'd0, alu_ready}, 32'd1);
        chk("tie_mov_ready", 102, {31'd0, mov_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("tie_we", 102, {31'd0, write_enabled}, 32'd1);
        chk("tie_rr", 102, {31'd0, reg_to_reg}, 32'd0);
        chk("tie_wd", 102, {24'd0, reg_write_data}, 32'h42);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
